// File: rtl/riscv_ascon_round_ctrl.sv
// Ascon-p round sequencer for the ASCON-mapped integer registers.
// Accepts a permutation request from ID and waits out any pending regular
// write-back. It then issues one round per cycle, with round constant and
// regfile update strobe, and stalls the pipeline until completion.
// Optional: define ASCON_PERF_CNT_EN to get a completed-permutation counter.
module riscv_ascon_round_ctrl #(
    parameter int unsigned MAX_ROUNDS = 12,
    parameter int unsigned RC_WIDTH   = 8,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] rounds_i,
    input  logic                 wb_pending_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    output logic                 stall_o,
    output logic                 busy_o,
    output logic [RC_WIDTH-1:0]  round_const_o,
    output logic                 we_ascon_update_o,
    output logic                 done_o,
    output logic [31:0]          perm_count_o
);

    localparam logic [CNT_WIDTH-1:0] MAX_R  = CNT_WIDTH'(MAX_ROUNDS);
    localparam logic [CNT_WIDTH-1:0] LAST_R = CNT_WIDTH'(MAX_ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_WB = 2'd1,
        ROUND   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] r_idx, r_idx_next;
    logic [CNT_WIDTH-1:0] n_clamp_c;
    logic [3:0]           r_lo_c;
    logic [RC_WIDTH-1:0]  rc_next_c;

    // Requested round count, saturated at the full permutation length.
    assign n_clamp_c = (rounds_i > MAX_R) ? MAX_R : rounds_i;

    // Next state and next round index.
    always_comb begin
        state_next = state;
        r_idx_next = r_idx;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    r_idx_next = MAX_R - n_clamp_c;
                    if (n_clamp_c == '0)
                        state_next = DONE;
                    else if (wb_pending_i)
                        state_next = WAIT_WB;
                    else
                        state_next = ROUND;
                end
            end
            WAIT_WB: begin
                if (flush_i)
                    state_next = IDLE;
                else if (!wb_pending_i)
                    state_next = ROUND;
            end
            ROUND: begin
                // Flush is ignored here: the instruction has already committed.
                if (r_idx == LAST_R)
                    state_next = DONE;
                else
                    r_idx_next = r_idx + CNT_WIDTH'(1);
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Round constant for the upcoming cycle: high nibble counts down, low counts up.
    assign r_lo_c    = 4'(r_idx_next);
    assign rc_next_c = (state_next == ROUND) ? RC_WIDTH'({4'(4'hF - r_lo_c), r_lo_c}) : '0;

    // State register and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            r_idx             <= '0;
            ready_o           <= 1'b1;
            busy_o            <= 1'b0;
            we_ascon_update_o <= 1'b0;
            done_o            <= 1'b0;
            round_const_o     <= '0;
        end else begin
            state             <= state_next;
            r_idx             <= r_idx_next;
            ready_o           <= (state_next == IDLE);
            busy_o            <= (state_next != IDLE);
            we_ascon_update_o <= (state_next == ROUND);
            done_o            <= (state_next == DONE);
            round_const_o     <= rc_next_c;
        end
    end

    // Stall must also cover the accept cycle itself, so it includes start_i.
    assign stall_o = (state != IDLE) || start_i;

`ifdef ASCON_PERF_CNT_EN
    logic [31:0] perm_count_q;

    // Completed-permutation counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perm_count_q <= '0;
        else if (done_o)
            perm_count_q <= perm_count_q + 32'd1;
    end

    assign perm_count_o = perm_count_q;
`else
    assign perm_count_o = '0;
`endif

endmodule
